// File: rtl/clk_tick_sched.sv
// Tick scheduler: round-robin shares one clock-enable generator between two
// requesters, each asking for a burst of cnt ticks spaced div cycles apart.
module clk_tick_sched #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    input  logic [2*DIV_W-1:0]   div_i,
    input  logic [2*CNT_W-1:0]   cnt_i,
    input  logic                 stop,
    output logic [1:0]           grant,
    output logic                 busy,
    output logic                 tick,
    output logic                 done,
    output logic                 aborted
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    state_t             state_n;
    logic               owner;
    logic               last;
    logic               ab_q;
    logic               ab_n;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   presc;
    logic [CNT_W-1:0]   rem;
    logic               win;
    logic [DIV_W-1:0]   win_div;
    logic [CNT_W-1:0]   win_cnt;

    // On a tie the requester that did not own the last burst wins.
    always_comb begin
        win     = (req == 2'b10) || ((req == 2'b11) && !last);
        win_div = win ? div_i[2*DIV_W-1:DIV_W] : div_i[DIV_W-1:0];
        win_cnt = win ? cnt_i[2*CNT_W-1:CNT_W] : cnt_i[CNT_W-1:0];
        if (win_div == '0) begin
            win_div = DIV_W'(1);
        end
    end

    always_comb begin
        state_n = state;
        ab_n    = ab_q;
        tick    = (state == RUN) && (presc == div_q - DIV_W'(1));
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    ab_n    = 1'b0;
                    state_n = (win_cnt == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // A final tick wins over a coincident stop.
                if (tick && rem == CNT_W'(1)) begin
                    state_n = DONE;
                    ab_n    = 1'b0;
                end else if (stop) begin
                    state_n = DONE;
                    ab_n    = 1'b1;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        busy    = (state == RUN);
        done    = (state == DONE);
        aborted = (state == DONE) && ab_q;
        grant   = (state == IDLE) ? 2'b00 : {owner, !owner};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ab_q  <= 1'b0;
        end else begin
            state <= state_n;
            ab_q  <= ab_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last  <= 1'b1;
            owner <= 1'b0;
            div_q <= '0;
            presc <= '0;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        owner <= win;
                        div_q <= win_div;
                        rem   <= win_cnt;
                        presc <= '0;
                    end
                end
                RUN: begin
                    if (tick) begin
                        presc <= '0;
                        rem   <= rem - CNT_W'(1);
                    end else begin
                        presc <= presc + DIV_W'(1);
                    end
                end
                DONE:    last <= owner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_tick_sched.sv
// Self-checking bench for clk_tick_sched: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a burst model.
module tb_clk_tick_sched;

    localparam int DIV_W = 8;
    localparam int CNT_W = 16;

    logic                 clk   = 1'b0;
    logic                 rst   = 1'b1;
    logic [1:0]           req   = 2'b00;
    logic [2*DIV_W-1:0]   div_i = '0;
    logic [2*CNT_W-1:0]   cnt_i = '0;
    logic                 stop  = 1'b0;
    logic [1:0]           grant;
    logic                 busy;
    logic                 tick;
    logic                 done;
    logic                 aborted;

    int tests_run    = 0;
    int tests_failed = 0;

    clk_tick_sched #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .div_i   (div_i),
        .cnt_i   (cnt_i),
        .stop    (stop),
        .grant   (grant),
        .busy    (busy),
        .tick    (tick),
        .done    (done),
        .aborted (aborted)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run = tests_run + 1;
        if (actual !== expected) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input int d0, input int c0,
                                 input int d1, input int c1);
        req   = r;
        div_i = {DIV_W'(d1), DIV_W'(d0)};
        cnt_i = {CNT_W'(c1), CNT_W'(c0)};
    endtask

    // Burst model: phase 0 idle, 1 running, 2 finishing; elapsed counts the
    // running cycles from 1, so a tick is due whenever elapsed is a multiple of div.
    int m_phase, m_owner, m_last, m_div, m_cnt, m_elapsed, m_ticks;
    bit m_ab;
    bit m_valid = 1'b0;

    always @(posedge clk) begin : model_update
        int w, d, c;
        bit t;
        if (rst) begin
            m_phase <= 0;
            m_last  <= 1;
            m_valid <= 1'b1;
        end else if (m_valid) begin
            case (m_phase)
                0: begin
                    if (req != 2'b00) begin
                        w = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
                        d = w ? int'(div_i[2*DIV_W-1:DIV_W]) : int'(div_i[DIV_W-1:0]);
                        c = w ? int'(cnt_i[2*CNT_W-1:CNT_W]) : int'(cnt_i[CNT_W-1:0]);
                        if (d == 0) d = 1;
                        m_owner   <= w;
                        m_div     <= d;
                        m_cnt     <= c;
                        m_elapsed <= 1;
                        m_ticks   <= 0;
                        m_ab      <= 1'b0;
                        m_phase   <= (c == 0) ? 2 : 1;
                    end
                end
                1: begin
                    t = (m_elapsed % m_div) == 0;
                    if (t && m_ticks + 1 == m_cnt) begin
                        m_phase <= 2;
                        m_ab    <= 1'b0;
                    end else if (stop) begin
                        m_phase <= 2;
                        m_ab    <= 1'b1;
                    end
                    if (t) m_ticks <= m_ticks + 1;
                    m_elapsed <= m_elapsed + 1;
                end
                default: begin
                    m_last  <= m_owner;
                    m_phase <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("grant", 32'(grant),
                        (m_phase != 0) ? (m_owner ? 32'd2 : 32'd1) : 32'd0);
            checkOutput("busy", 32'(busy), 32'(m_phase == 1));
            checkOutput("tick", 32'(tick),
                        32'((m_phase == 1) && ((m_elapsed % m_div) == 0)));
            checkOutput("done", 32'(done), 32'(m_phase == 2));
            checkOutput("aborted", 32'(aborted), 32'((m_phase == 2) && m_ab));
        end
    end

    initial begin
        logic [12:0] mask13;
        logic [6:0]  mask7;
        logic [3:0]  mask4;
        logic [5:0]  seq;
        int          nticks;
        int          nbursts;
        bit          grant_ok;
        bit          prev_busy;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a burst, then a tie goes to requester 0.
        applyStimulus(2'b01, 4, 10, 0, 0);
        @(negedge clk);
        req = 2'b00;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_grant", 32'(grant), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_tick", 32'(tick), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        applyStimulus(2'b11, 1, 1, 1, 1);
        @(negedge clk);
        checkOutput("rst_tie_grant", 32'(grant), 32'd1);
        req = 2'b00;
        repeat (4) @(negedge clk);

        // Single burst div 3 cnt 4.
        applyStimulus(2'b01, 3, 4, 0, 0);
        mask13   = '0;
        grant_ok = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 1) req = 2'b00;
            mask13[k-1] = tick;
            if (grant !== 2'b01) grant_ok = 1'b0;
            if (k == 13) begin
                checkOutput("single_done", 32'(done), 32'd1);
                checkOutput("single_aborted", 32'(aborted), 32'd0);
            end
        end
        checkOutput("single_ticks", 32'(mask13), 32'h924);
        checkOutput("single_grant", 32'(grant_ok), 32'd1);
        repeat (3) @(negedge clk);

        // Round robin with both requesting continuously.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(2'b11, 1, 2, 1, 2);
        seq       = '0;
        nbursts   = 0;
        nticks    = 0;
        prev_busy = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy && !prev_busy && nbursts < 3) begin
                seq     = {seq[3:0], grant};
                nbursts = nbursts + 1;
            end
            nticks    = nticks + int'(tick);
            prev_busy = busy;
        end
        checkOutput("rr_grant_seq", 32'(seq), 32'b01_10_01);
        checkOutput("rr_ticks", 32'(nticks), 32'd6);
        req = 2'b00;
        repeat (4) @(negedge clk);

        // Zero count goes straight to completion.
        applyStimulus(2'b01, 5, 0, 0, 0);
        @(negedge clk);
        req = 2'b00;
        checkOutput("zero_cnt_done", 32'(done), 32'd1);
        checkOutput("zero_cnt_busy", 32'(busy), 32'd0);
        checkOutput("zero_cnt_tick", 32'(tick), 32'd0);
        checkOutput("zero_cnt_aborted", 32'(aborted), 32'd0);
        @(negedge clk);
        checkOutput("zero_cnt_after", 32'({busy, done}), 32'd0);
        repeat (2) @(negedge clk);

        // Zero divider behaves as one: back-to-back ticks.
        applyStimulus(2'b01, 0, 3, 0, 0);
        mask4 = '0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) req = 2'b00;
            mask4[k-1] = tick;
            if (k == 4) checkOutput("zero_div_done", 32'(done), 32'd1);
        end
        checkOutput("zero_div_ticks", 32'(mask4), 32'b0111);
        repeat (2) @(negedge clk);

        // Abort after the second tick.
        applyStimulus(2'b01, 5, 8, 0, 0);
        nticks = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) req = 2'b00;
            if (k == 12) stop = 1'b0;
            nticks = nticks + int'(tick);
            if (k == 11) stop = 1'b1;
        end
        checkOutput("abort_done", 32'(done), 32'd1);
        checkOutput("abort_aborted", 32'(aborted), 32'd1);
        checkOutput("abort_ticks", 32'(nticks), 32'd2);
        repeat (2) @(negedge clk);

        // Stop on the final tick is a normal completion.
        applyStimulus(2'b01, 5, 8, 0, 0);
        nticks = 0;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            if (k == 1) req = 2'b00;
            if (k == 41) stop = 1'b0;
            nticks = nticks + int'(tick);
            if (k == 40) stop = 1'b1;
        end
        checkOutput("final_stop_done", 32'(done), 32'd1);
        checkOutput("final_stop_aborted", 32'(aborted), 32'd0);
        checkOutput("final_stop_ticks", 32'(nticks), 32'd8);
        repeat (2) @(negedge clk);

        // Inputs changing during a burst are ignored.
        applyStimulus(2'b10, 7, 9, 2, 3);
        mask7    = '0;
        grant_ok = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 2) applyStimulus(2'b01, 1, 50, 1, 50);
            mask7[k-1] = tick;
            if (grant !== 2'b10) grant_ok = 1'b0;
            if (k == 7) begin
                checkOutput("ignore_done", 32'(done), 32'd1);
                req = 2'b00;
            end
        end
        checkOutput("ignore_ticks", 32'(mask7), 32'h2A);
        checkOutput("ignore_grant", 32'(grant_ok), 32'd1);
        repeat (3) @(negedge clk);

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) req = 2'($urandom_range(0, 3));
            div_i = {DIV_W'($urandom_range(0, 6)), DIV_W'($urandom_range(0, 6))};
            cnt_i = {CNT_W'($urandom_range(0, 5)), CNT_W'($urandom_range(0, 5))};
            stop  = ($urandom_range(0, 9) == 0);
            rst   = ($urandom_range(0, 199) == 0);
        end
        rst  = 1'b0;
        stop = 1'b0;
        req  = 2'b00;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
